// File: rtl/sram_req_ctrl_if.sv
// Single-port SRAM macro port. The slave modport is the controller side that
// drives the strobes and samples the one-cycle-latency read data.
interface sram_if #(
  parameter int BIT_WIDTH  = 64,
  parameter int WORD_DEPTH = 512
);
  localparam int AW = $clog2(WORD_DEPTH);

  logic                   en_i;
  logic                   wen_i;
  logic [BIT_WIDTH/8-1:0] bm_i;
  logic [AW-1:0]          addr_i;
  logic [BIT_WIDTH-1:0]   dat_i;
  logic [BIT_WIDTH-1:0]   dat_o;

  modport slave (output en_i, wen_i, bm_i, addr_i, dat_i, input dat_o);
  modport macro (input en_i, wen_i, bm_i, addr_i, dat_i, output dat_o);
endinterface

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end for a single-port SRAM with a credit-protected
// response FIFO, so read data is never dropped under response backpressure.
module sram_req_ctrl #(
  parameter int BIT_WIDTH  = 64,
  parameter int WORD_DEPTH = 512,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_we_i,
  input  logic [BIT_WIDTH/8-1:0]        req_bm_i,
  input  logic [$clog2(WORD_DEPTH)-1:0] req_addr_i,
  input  logic [BIT_WIDTH-1:0]          req_dat_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [BIT_WIDTH-1:0]          rsp_dat_o,
  sram_if.slave                         sram
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(RSP_DEPTH - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        occ_q, occ_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [BIT_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [BIT_WIDTH-1:0] fifo_d [RSP_DEPTH];

  logic accept, rd_acc, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on the request and registered credits, never on rsp_ready_i.
  assign req_ready_o = rst_n_i & (req_we_i | (cnt_q < CNT_MAX));
  assign accept      = req_valid_i & req_ready_o;
  assign rd_acc      = accept & ~req_we_i;
  assign push        = rd_pend_q;
  assign rsp_valid_o = (occ_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_dat_o   = rsp_valid_o ? fifo_q[rd_ptr_q] : '0;

  assign sram.en_i   = accept;
  assign sram.wen_i  = accept & req_we_i;
  assign sram.bm_i   = (accept & req_we_i) ? req_bm_i : '0;
  assign sram.addr_i = req_addr_i;
  assign sram.dat_i  = req_dat_i;

  always_comb begin
    cnt_d     = cnt_q;
    occ_d     = occ_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_pend_d = rd_acc;
    fifo_d    = fifo_q;
    if (rd_acc && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!rd_acc && pop) cnt_d = cnt_q - 1'b1;
    if (push && !pop)        occ_d = occ_q + 1'b1;
    else if (!push && pop)   occ_d = occ_q - 1'b1;
    if (push) begin
      fifo_d[wr_ptr_q] = sram.dat_o;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
    if (!rst_n_i) begin
      cnt_q     <= '0;
      occ_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      assert (!(push && occ_q == CNT_MAX));
      cnt_q     <= cnt_d;
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_pend_q <= rd_pend_d;
    end
  end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Scoreboard bench: a monitor tracks accepted requests against a word-level
// memory model and checks handshakes, strobes, latency and in-order read data.
module tb_sram_req_ctrl;
  localparam int BW = 64;
  localparam int WD = 512;
  localparam int AW = $clog2(WD);
  localparam int RD = 3;

  typedef struct { logic [BW-1:0] dat; int cyc; } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic          req_ready, rsp_valid;
  logic [BW/8-1:0] req_bm = '0;
  logic [AW-1:0] req_addr = '0;
  logic [BW-1:0] req_dat = '0, rsp_dat;

  sram_if #(.BIT_WIDTH(BW), .WORD_DEPTH(WD)) sif ();

  sram_req_ctrl #(.BIT_WIDTH(BW), .WORD_DEPTH(WD), .RSP_DEPTH(RD)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_bm_i(req_bm), .req_addr_i(req_addr), .req_dat_i(req_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .sram(sif.slave)
  );

  always #5 clk = ~clk;

  // SRAM macro: one-cycle read latency, byte-masked writes.
  logic [BW-1:0] sram_mem [WD];
  always @(posedge clk) begin
    if (sif.en_i) begin
      if (sif.wen_i) begin
        for (int b = 0; b < BW/8; b++)
          if (sif.bm_i[b]) sram_mem[sif.addr_i][b*8 +: 8] <= sif.dat_i[b*8 +: 8];
      end else begin
        sif.dat_o <= sram_mem[sif.addr_i];
      end
    end
  end

  int errors = 0, checks = 0, cyc = 0;
  int n_rd = 0, n_wr = 0, n_pop = 0, n_rd_blocked = 0;
  logic [BW-1:0] ref_mem [WD];
  logic [BW-1:0] last_pop = '0;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("ready_in_reset", {63'd0, req_ready}, 64'd0);
      chk("en_in_reset", {63'd0, sif.en_i}, 64'd0);
      chk("wen_in_reset", {63'd0, sif.wen_i}, 64'd0);
      exp_q.delete();
    end else begin
      logic exp_rdy, exp_vld, acc;
      exp_rdy = req_we || (exp_q.size() < RD);
      exp_vld = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
      acc     = req_valid && exp_rdy;
      chk("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
      chk("credits", 64'(dut.cnt_q), 64'(exp_q.size()));
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_vld});
      if (!rsp_valid) chk("rsp_dat_idle", rsp_dat, '0);
      chk("sram_en", {63'd0, sif.en_i}, {63'd0, acc});
      chk("sram_wen", {63'd0, sif.wen_i}, {63'd0, acc && req_we});
      chk("sram_bm", 64'(sif.bm_i), (acc && req_we) ? 64'(req_bm) : 64'd0);
      if (req_valid && !req_we && !exp_rdy) n_rd_blocked++;
      if (rsp_valid && rsp_ready && exp_vld) begin
        chk("rsp_dat", rsp_dat, exp_q[0].dat);
        last_pop = rsp_dat;
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (acc) begin
        if (req_we) begin
          for (int b = 0; b < BW/8; b++)
            if (req_bm[b]) ref_mem[req_addr][b*8 +: 8] = req_dat[b*8 +: 8];
          n_wr++;
        end else begin
          exp_q.push_back('{dat: ref_mem[req_addr], cyc: cyc});
          n_rd++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one request and hold it until the handshake completes.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [BW/8-1:0] bm,
                       input logic [BW-1:0] d);
    bit done = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_bm = bm; req_dat = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1;
      step();
    end
    if (!done) begin errors++; checks++; $display("FAIL issue_timeout got no accept expected accept"); end
    req_valid = 1'b0;
  endtask

  initial begin
    int r0, p0, b0, w0;
    for (int i = 0; i < WD; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
    sif.dat_o = '0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_dat", rsp_dat, '0);
    step();

    // Write then read.
    rsp_ready = 1'b1;
    issue(1'b1, 9'h10, 8'hFF, 64'h1122334455667788);
    issue(1'b0, 9'h10, 8'h00, '0);
    repeat (4) step();
    chk("wr_rd_data", last_pop, 64'h1122334455667788);

    // Byte mask.
    issue(1'b1, 9'h20, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, 9'h20, 8'h0F, 64'h0);
    issue(1'b0, 9'h20, 8'h00, '0);
    repeat (4) step();
    chk("byte_mask", last_pop, 64'hFFFF_FFFF_0000_0000);

    // Streaming reads: one accept per cycle.
    for (int i = 0; i < 8; i++) issue(1'b1, 9'(i), 8'hFF, {32'hA5A5_0000, 32'(i)});
    r0 = n_rd; p0 = n_pop; b0 = n_rd_blocked;
    for (int i = 0; i < 8; i++) issue(1'b0, 9'(i), 8'h00, '0);
    repeat (5) step();
    chk("stream_no_stall", 64'(n_rd_blocked - b0), 64'd0);
    chk("stream_pops", 64'(n_pop - p0), 64'd8);
    chk("stream_last", last_pop, {32'hA5A5_0000, 32'd7});

    // Backpressure: only RD reads fit, writes still go through.
    rsp_ready = 1'b0;
    r0 = n_rd; p0 = n_pop; w0 = n_wr;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h3;
    repeat (10) step();
    chk("bp_reads", 64'(n_rd - r0), 64'(RD));
    req_valid = 1'b0;
    issue(1'b1, 9'h40, 8'hFF, 64'hDEAD_BEEF_0000_0001);
    chk("bp_write", 64'(n_wr - w0), 64'd1);
    rsp_ready = 1'b1;
    repeat (6) step();
    chk("bp_drain", 64'(n_pop - p0), 64'(RD));
    issue(1'b0, 9'h40, 8'h00, '0);
    repeat (4) step();
    chk("bp_resume", last_pop, 64'hDEAD_BEEF_0000_0001);

    // Reset while a read is in flight.
    p0 = n_pop;
    issue(1'b0, 9'h10, 8'h00, '0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("rst_mid_no_rsp", 64'(n_pop - p0), 64'd0);
    chk("rst_mid_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_mid_cnt", 64'(dut.cnt_q), 64'd0);

    // Random interleave.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 9'($urandom_range(0, 15));
      req_bm    = 8'($urandom);
      req_dat   = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      step();
    end
    req_valid = 1'b0; rst_n = 1'b1; rsp_ready = 1'b1;
    repeat (8) step();
    chk("final_empty", {63'd0, rsp_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
